// File: rtl/ex_operand_ctrl.sv
// EX-stage operand control: ID/EX control latch, load-use stall FSM, A/B forwarding selects.
// Latency: the ID/EX latch is one cycle. stall, fwd_a, fwd_b and alu_src_sel are combinational from the current state.
// Backpressure: ext_stall freezes all state, including the stall counter. A load-use hazard holds IF/ID for LU_CYCLES cycles.
//
// Ports:
//   clk, reset             rising-edge clock; synchronous active-high reset (takes priority over ext_stall)
//   ext_stall              global freeze, e.g. while waiting on memory
//   id_*                   fields of the instruction currently in ID
//   exmem_*, memwb_*       register-write info from later stages, used for forwarding
//   stall                  hold PC and IF/ID this cycle; a bubble enters EX on the next edge
//   fwd_a, fwd_b           operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   alu_src_sel            1 = sign-extended immediate on operand B
//   ex_valid/ex_rd/ex_mem_read   latched EX-stage fields
//   stall_count            saturating count of stalled cycles
module ex_operand_ctrl #(
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_stall,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_mem_read,
    input  logic             id_alu_src,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_rd,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_rd,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             alu_src_sel,
    output logic             ex_valid,
    output logic [4:0]       ex_rd,
    output logic             ex_mem_read,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // The hold counter only has to reach LU_CYCLES-2. The first stall cycle is spent in RUN.
    localparam int CW = (LU_CYCLES > 2) ? $clog2(LU_CYCLES - 1) : 1;
    localparam logic [CW-1:0] HOLD_INIT = (LU_CYCLES > 1) ? CW'(LU_CYCLES - 2) : '0;

    logic [0:0]    state;
    logic [CW-1:0] holdCnt;
    logic [4:0]    exRs;
    logic [4:0]    exRt;
    logic          exAluSrc;

    logic hz;
    logic stallInt;
    logic rsHit;
    logic rtHit;

    // The load destination travels in ex_rt.
    assign rsHit = (exRt == id_rs);
    assign rtHit = id_uses_rt && (exRt == id_rt);

    assign hz = (state == RUN) && id_valid && ex_valid && ex_mem_read
                && (exRt != 5'd0) && (rsHit || rtHit);

    assign stallInt = (state == HOLD) || hz;

    // Combinational outputs are forced quiet while reset is asserted.
    // Any stale state then cannot leak out before the first reset edge.
    assign stall = stallInt && !reset;

    function automatic logic [1:0] fwdSel(
        input logic [4:0] src,
        input logic       xmWrite,
        input logic [4:0] xmRd,
        input logic       mwWrite,
        input logic [4:0] mwRd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (xmWrite && (xmRd != 5'd0) && (xmRd == src)) begin
            sel = 2'b10;
        end else if (mwWrite && (mwRd != 5'd0) && (mwRd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        alu_src_sel = 1'b0;
        if (ex_valid && !reset) begin
            fwd_a       = fwdSel(exRs, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
            // Operand B is still resolved when the immediate is selected.
            // Stores need the forwarded rt value as write data.
            fwd_b       = fwdSel(exRt, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
            alu_src_sel = exAluSrc;
        end
    end

    // Stall FSM. The detect cycle is the first stall cycle, so HOLD covers the remaining LU_CYCLES-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            holdCnt <= '0;
        end else if (!ext_stall) begin
            case (state)
                RUN: begin
                    if (hz && (LU_CYCLES > 1)) begin
                        state   <= HOLD;
                        holdCnt <= HOLD_INIT;
                    end
                end
                HOLD: begin
                    if (holdCnt == '0) begin
                        state <= RUN;
                    end else begin
                        holdCnt <= holdCnt - 1'b1;
                    end
                end
                default: begin
                    state   <= RUN;
                    holdCnt <= '0;
                end
            endcase
        end
    end

    // ID/EX latch. On a stall only ex_valid drops; the other fields keep their values because nothing reads them.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            exRs        <= 5'd0;
            exRt        <= 5'd0;
            ex_rd       <= 5'd0;
            ex_mem_read <= 1'b0;
            exAluSrc    <= 1'b0;
        end else if (!ext_stall) begin
            if (stallInt) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                exRs        <= id_rs;
                exRt        <= id_rt;
                ex_rd       <= id_rd;
                ex_mem_read <= id_mem_read;
                exAluSrc    <= id_alu_src;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!ext_stall && stallInt && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_operand_ctrl.sv
module tb_ex_operand_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ext_stall, ext_stall3;
    logic       id_valid, id_valid3;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rt, id_mem_read, id_alu_src;
    logic       exmem_reg_write, memwb_reg_write;
    logic [4:0] exmem_rd, memwb_rd;

    logic        stall1, alu1, exv1, exmr1;
    logic [1:0]  fa1, fb1;
    logic [4:0]  exrd1;
    logic [15:0] cnt1;
    logic        stall3, alu3, exv3, exmr3;
    logic [1:0]  fa3, fb3;
    logic [4:0]  exrd3;
    logic [15:0] cnt3;

    ex_operand_ctrl #(.LU_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .id_alu_src(id_alu_src),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .stall(stall1), .fwd_a(fa1), .fwd_b(fb1), .alu_src_sel(alu1),
        .ex_valid(exv1), .ex_rd(exrd1), .ex_mem_read(exmr1), .stall_count(cnt1)
    );

    ex_operand_ctrl #(.LU_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .ext_stall(ext_stall3), .id_valid(id_valid3),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_mem_read(id_mem_read), .id_alu_src(id_alu_src),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .stall(stall3), .fwd_a(fa3), .fwd_b(fb3), .alu_src_sel(alu3),
        .ex_valid(exv3), .ex_rd(exrd3), .ex_mem_read(exmr3), .stall_count(cnt3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       vld;
        logic [4:0] rs, rt;
        logic       usesRt;
        logic [4:0] rd;
        logic       memRead, aluSrc;
        logic       xmW;
        logic [4:0] xmRd;
        logic       mwW;
        logic [4:0] mwRd;
        logic       eStall;
        logic       eValid;
        logic [4:0] eRd;
        logic       eMemRead;
        logic [1:0] eFwdA, eFwdB;
        logic       eAlu;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic       memRead;
        logic [1:0] fwdA, fwdB;
        logic       alu;
    } exp_t;

    localparam int N = 10;
    vec_t vecs [N];
    exp_t sb [$];
    exp_t e;
    int   stallCycles;

    initial begin
        //            vld rs    rt    uR  rd    mr  as  xmW xmRd  mwW mwRd  stl  v  eRd   eMr fA     fB     alu
        vecs[0] = '{1'b1,5'd5,5'd5,1'b1,5'd3,1'b0,1'b0,1'b1,5'd5,1'b1,5'd5,1'b0,1'b1,5'd3,1'b0,2'b10,2'b10,1'b0};
        vecs[1] = '{1'b1,5'd5,5'd5,1'b1,5'd4,1'b0,1'b0,1'b0,5'd5,1'b1,5'd5,1'b0,1'b1,5'd4,1'b0,2'b01,2'b01,1'b0};
        vecs[2] = '{1'b1,5'd0,5'd7,1'b1,5'd2,1'b0,1'b0,1'b1,5'd0,1'b1,5'd7,1'b0,1'b1,5'd2,1'b0,2'b00,2'b01,1'b0};
        vecs[3] = '{1'b1,5'd6,5'd9,1'b0,5'd9,1'b0,1'b1,1'b1,5'd9,1'b0,5'd0,1'b0,1'b1,5'd9,1'b0,2'b00,2'b10,1'b1};
        vecs[4] = '{1'b1,5'd1,5'd0,1'b0,5'd0,1'b1,1'b1,1'b0,5'd0,1'b0,5'd0,1'b0,1'b1,5'd0,1'b1,2'b00,2'b00,1'b1};
        vecs[5] = '{1'b1,5'd0,5'd0,1'b1,5'd8,1'b0,1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,1'b1,5'd8,1'b0,2'b00,2'b00,1'b0};
        vecs[6] = '{1'b0,5'd3,5'd3,1'b1,5'd3,1'b0,1'b0,1'b1,5'd3,1'b1,5'd3,1'b0,1'b0,5'd3,1'b0,2'b00,2'b00,1'b0};
        vecs[7] = '{1'b1,5'd2,5'd8,1'b0,5'd8,1'b1,1'b1,1'b1,5'd2,1'b0,5'd0,1'b0,1'b1,5'd8,1'b1,2'b10,2'b00,1'b1};
        vecs[8] = '{1'b1,5'd3,5'd4,1'b1,5'd5,1'b0,1'b0,1'b0,5'd0,1'b1,5'd4,1'b0,1'b1,5'd5,1'b0,2'b00,2'b01,1'b0};
        vecs[9] = '{1'b1,5'd8,5'd8,1'b0,5'd6,1'b0,1'b0,1'b0,5'd8,1'b0,5'd8,1'b0,1'b1,5'd6,1'b0,2'b00,2'b00,1'b0};

        reset = 1'b1; ext_stall = 1'b1; ext_stall3 = 1'b1;
        id_valid = 1'b0; id_valid3 = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_uses_rt = 1'b0; id_mem_read = 1'b0; id_alu_src = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_reg_write = 1'b1; memwb_rd = 5'd0;

        // Reset must win over ext_stall.
        @(posedge clk); #1;
        check("rst_ex_valid", {31'd0, exv1}, 32'd0);
        check("rst_stall", {31'd0, stall1}, 32'd0);
        check("rst_fwd_a", {30'd0, fa1}, 32'd0);
        check("rst_fwd_b", {30'd0, fb1}, 32'd0);
        check("rst_count", {16'd0, cnt1}, 32'd0);
        check("rst_count3", {16'd0, cnt3}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; ext_stall = 1'b0; ext_stall3 = 1'b0;
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // Table vectors: stall is checked before the edge, and EX-side results one cycle later via the queue.
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                check($sformatf("v%0d_ex_valid", i-1), {31'd0, exv1}, {31'd0, e.valid});
                check($sformatf("v%0d_ex_rd", i-1), {27'd0, exrd1}, {27'd0, e.rd});
                check($sformatf("v%0d_ex_mem_read", i-1), {31'd0, exmr1}, {31'd0, e.memRead});
                check($sformatf("v%0d_fwd_a", i-1), {30'd0, fa1}, {30'd0, e.fwdA});
                check($sformatf("v%0d_fwd_b", i-1), {30'd0, fb1}, {30'd0, e.fwdB});
                check($sformatf("v%0d_alu_src_sel", i-1), {31'd0, alu1}, {31'd0, e.alu});
            end
            if (i < N) begin
                id_valid = vecs[i].vld; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
                id_uses_rt = vecs[i].usesRt; id_rd = vecs[i].rd;
                id_mem_read = vecs[i].memRead; id_alu_src = vecs[i].aluSrc;
                exmem_reg_write = vecs[i].xmW; exmem_rd = vecs[i].xmRd;
                memwb_reg_write = vecs[i].mwW; memwb_rd = vecs[i].mwRd;
                #1;
                check($sformatf("v%0d_stall", i), {31'd0, stall1}, {31'd0, vecs[i].eStall});
                sb.push_back('{vecs[i].vld, vecs[i].eRd, vecs[i].eMemRead,
                               vecs[i].eFwdA, vecs[i].eFwdB, vecs[i].eAlu});
            end
        end
        check("v_no_stall_count", {16'd0, cnt1}, 32'd0);

        // Load-use with LU_CYCLES=1: lw $8, then a consumer reading $8 through rs.
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd8; id_uses_rt = 1'b0; id_rd = 5'd8;
        id_mem_read = 1'b1; id_alu_src = 1'b1;
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
        @(negedge clk);
        id_rs = 5'd8; id_rt = 5'd2; id_uses_rt = 1'b1; id_rd = 5'd10;
        id_mem_read = 1'b0; id_alu_src = 1'b0;
        #1;
        check("lu1_stall_detect", {31'd0, stall1}, 32'd1);
        @(negedge clk);
        check("lu1_bubble", {31'd0, exv1}, 32'd0);
        check("lu1_stall_released", {31'd0, stall1}, 32'd0);
        check("lu1_count", {16'd0, cnt1}, 32'd1);
        memwb_reg_write = 1'b1; memwb_rd = 5'd8;
        @(negedge clk);
        check("lu1_enter_valid", {31'd0, exv1}, 32'd1);
        check("lu1_enter_rd", {27'd0, exrd1}, 32'd10);
        check("lu1_fwd_a", {30'd0, fa1}, 32'b01);
        check("lu1_fwd_b", {30'd0, fb1}, 32'b00);
        check("lu1_count_hold", {16'd0, cnt1}, 32'd1);
        id_valid = 1'b0; memwb_reg_write = 1'b0;

        // Load-use with LU_CYCLES=3, ext_stall held for two cycles inside HOLD.
        id_valid3 = 1'b1; id_rs = 5'd1; id_rt = 5'd8; id_uses_rt = 1'b0; id_rd = 5'd8;
        id_mem_read = 1'b1; id_alu_src = 1'b1;
        @(negedge clk);
        id_rs = 5'd8; id_rt = 5'd3; id_uses_rt = 1'b1; id_rd = 5'd11;
        id_mem_read = 1'b0; id_alu_src = 1'b0;
        stallCycles = 0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            ext_stall3 = (k == 1 || k == 2);
            #1;
            if (stall3) stallCycles++;
        end
        ext_stall3 = 1'b0;
        check("lu3_stall_cycles", stallCycles, 32'd5);
        check("lu3_count", {16'd0, cnt3}, 32'd3);
        check("lu3_enter_valid", {31'd0, exv3}, 32'd1);
        check("lu3_enter_rd", {27'd0, exrd3}, 32'd11);
        id_valid3 = 1'b0;

        // Reset while in HOLD abandons the partial stall.
        @(negedge clk);
        id_valid3 = 1'b1; id_rs = 5'd1; id_rt = 5'd9; id_uses_rt = 1'b0; id_rd = 5'd9;
        id_mem_read = 1'b1;
        @(negedge clk);
        id_rs = 5'd9; id_rd = 5'd12; id_mem_read = 1'b0;
        #1;
        check("rh_detect", {31'd0, stall3}, 32'd1);
        @(negedge clk);
        check("rh_in_hold", {31'd0, stall3}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rh_stall_after_reset", {31'd0, stall3}, 32'd0);
        check("rh_ex_valid", {31'd0, exv3}, 32'd0);
        check("rh_count", {16'd0, cnt3}, 32'd0);
        @(negedge clk);
        check("rh_no_restall", {31'd0, stall3}, 32'd0);
        check("rh_consumer_enters", {31'd0, exv3}, 32'd1);
        id_valid3 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
